// File: rtl/ch_thresh_scan_ctrl_pkg.sv
// Shared types and default widths for the ultrasonic threshold-scan channel controllers.
package ch_thresh_scan_ctrl_pkg;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_DATA_W   = 24;
  localparam int DEF_TS_W     = 32;
  localparam int DEF_HOLD_CNT = 4;

  // Run counters only need to reach HOLD_CNT, which tops out at 15.
  localparam int RUN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SCAN  = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/ch_thresh_scan_ctrl_if.sv
// CPU/PIO and receive-channel signal bundle for ch_thresh_scan_ctrl.
interface ch_thresh_scan_ctrl_if #(
  parameter int NUM_CH = ch_thresh_scan_ctrl_pkg::DEF_NUM_CH,
  parameter int DATA_W = ch_thresh_scan_ctrl_pkg::DEF_DATA_W,
  parameter int TS_W   = ch_thresh_scan_ctrl_pkg::DEF_TS_W
) ();

  logic                     arm;
  logic                     abort;
  logic [15:0]              blank_cycles;
  logic [TS_W-1:0]          timeout;
  logic [NUM_CH*DATA_W-1:0] thresh_in;
  logic [NUM_CH-1:0]        sample_valid;
  logic [NUM_CH*DATA_W-1:0] sample_data;
  logic                     irq_ack;
  logic                     busy;
  logic                     irq;
  logic [NUM_CH-1:0]        hit_mask;
  logic [NUM_CH-1:0]        overrun;
  logic [NUM_CH*TS_W-1:0]   tof_ts;

  modport master (
    output arm, abort, blank_cycles, timeout, thresh_in, sample_valid, sample_data, irq_ack,
    input  busy, irq, hit_mask, overrun, tof_ts
  );

  modport slave (
    input  arm, abort, blank_cycles, timeout, thresh_in, sample_valid, sample_data, irq_ack,
    output busy, irq, hit_mask, overrun, tof_ts
  );

endinterface

// File: rtl/ch_thresh_scan_ctrl_arbiter.sv
// Round-robin arbiter: request vector -> one-hot grant; pointer moves past each winner.
module thresh_rr_arbiter #(
  parameter int NUM_CH = ch_thresh_scan_ctrl_pkg::DEF_NUM_CH,
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              gnt_vld
);

  logic [IDX_W-1:0] ptr;

  always_comb begin
    int               idx;
    logic [IDX_W-1:0] sel;
    idx     = 0;
    sel     = '0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      sel = IDX_W'(idx);
      if (!gnt_vld && req[sel]) begin
        gnt_vld  = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (gnt_vld) begin
      ptr <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/ch_thresh_scan_ctrl.sv
// Per-shot threshold-crossing controller: blanking, round-robin shared comparator,
// per-channel time-of-flight capture and done interrupt.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for arm; results from the last shot stay visible
//   ST_BLANK | transmit blanking, timer running, samples ignored
//   ST_SCAN  | samples captured and compared round-robin
//   ST_DONE  | one-cycle state, irq raised on entry
module ch_thresh_scan_ctrl
  import ch_thresh_scan_ctrl_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TS_W     = DEF_TS_W,
  parameter int HOLD_CNT = DEF_HOLD_CNT,
  localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input logic                  clk,
  input logic                  reset_n,
  ch_thresh_scan_ctrl_if.slave bus
);

  scan_state_e            state;
  logic [TS_W-1:0]        timer;
  logic [TS_W-1:0]        timer_inc;
  logic                   irq;
  logic [DATA_W-1:0]      thresh_q  [NUM_CH];
  logic [DATA_W-1:0]      hold_data [NUM_CH];
  logic [TS_W-1:0]        hold_ts   [NUM_CH];
  logic [RUN_W-1:0]       run_cnt   [NUM_CH];
  logic [NUM_CH-1:0]      hold_full;
  logic [NUM_CH-1:0]      hit_mask;
  logic [NUM_CH-1:0]      overrun;
  logic [NUM_CH*TS_W-1:0] tof_ts;

  logic [NUM_CH-1:0]      en_mask;
  logic [NUM_CH-1:0]      cap_vld;
  logic [NUM_CH-1:0]      load;
  logic [NUM_CH-1:0]      drop;
  logic [NUM_CH-1:0]      hit_next;
  logic [NUM_CH-1:0]      gnt;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   gnt_vld;
  logic                   scanning;
  logic                   start_shot;
  logic                   cmp_ge;
  logic [RUN_W-1:0]       run_inc;
  logic                   run_done;
  logic                   all_hit;
  logic                   timed_out;

  assign scanning   = (state == ST_SCAN);
  assign start_shot = (state == ST_IDLE) && bus.arm && !bus.abort;
  assign timer_inc  = (&timer) ? timer : timer + TS_W'(1);

  thresh_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (hold_full & {NUM_CH{scanning}}),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // The single shared comparator sees only the granted channel.
  assign cmp_ge    = (hold_data[gnt_idx] >= thresh_q[gnt_idx]);
  assign run_inc   = run_cnt[gnt_idx] + RUN_W'(1);
  assign run_done  = gnt_vld && cmp_ge && (run_inc == RUN_W'(HOLD_CNT));
  assign hit_next  = hit_mask | (run_done ? gnt : '0);
  assign all_hit   = ((hit_next & en_mask) == en_mask);
  // >= rather than == so a window shorter than the blanking still ends the shot.
  assign timed_out = (bus.timeout == '0) || (timer >= bus.timeout - TS_W'(1));

  always_comb begin
    en_mask = '0;
    cap_vld = '0;
    load    = '0;
    drop    = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      en_mask[ch] = (thresh_q[ch] != '0);
      cap_vld[ch] = scanning && bus.sample_valid[ch] && en_mask[ch] && !hit_next[ch];
      load[ch]    = cap_vld[ch] && (!hold_full[ch] || gnt[ch]);
      drop[ch]    = cap_vld[ch] && hold_full[ch] && !gnt[ch];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      timer <= '0;
      irq   <= 1'b0;
    end else begin
      if (bus.irq_ack) irq <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start_shot) begin
            state <= ST_BLANK;
            timer <= '0;
          end
        end
        ST_BLANK: begin
          timer <= timer_inc;
          if (bus.abort) state <= ST_IDLE;
          else if (timer == TS_W'(bus.blank_cycles)) state <= ST_SCAN;
        end
        ST_SCAN: begin
          timer <= timer_inc;
          if (bus.abort) begin
            state <= ST_IDLE;
          end else if (all_hit || timed_out) begin
            state <= ST_DONE;
            irq   <= !bus.irq_ack;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_full <= '0;
      hit_mask  <= '0;
      overrun   <= '0;
      tof_ts    <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        thresh_q[ch]  <= '0;
        hold_data[ch] <= '0;
        hold_ts[ch]   <= '0;
        run_cnt[ch]   <= '0;
      end
    end else if (start_shot) begin
      hold_full <= '0;
      hit_mask  <= '0;
      overrun   <= '0;
      tof_ts    <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        thresh_q[ch]  <= bus.thresh_in[ch*DATA_W +: DATA_W];
        hold_data[ch] <= '0;
        hold_ts[ch]   <= '0;
        run_cnt[ch]   <= '0;
      end
    end else begin
      hit_mask <= hit_next;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (load[ch]) begin
          hold_full[ch] <= 1'b1;
          hold_data[ch] <= bus.sample_data[ch*DATA_W +: DATA_W];
          hold_ts[ch]   <= timer;
        end else if (gnt[ch]) begin
          hold_full[ch] <= 1'b0;
        end
        if (drop[ch]) overrun[ch] <= 1'b1;
        if (gnt[ch]) run_cnt[ch] <= cmp_ge ? run_inc : '0;
        if (run_done && gnt[ch]) tof_ts[ch*TS_W +: TS_W] <= hold_ts[ch];
      end
    end
  end

  assign bus.busy     = (state == ST_BLANK) || (state == ST_SCAN);
  assign bus.irq      = irq;
  assign bus.hit_mask = hit_mask;
  assign bus.overrun  = overrun;
  assign bus.tof_ts   = tof_ts;

endmodule

// File: tb/tb_ch_thresh_scan_ctrl.sv
// Directed bench for ch_thresh_scan_ctrl: hit timing, hysteresis, blanking, overrun,
// early done, abort and reset.
module tb_ch_thresh_scan_ctrl;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 24;
  localparam int TS_W   = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   tb_t = 0;

  always #5 clk = ~clk;

  ch_thresh_scan_ctrl_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .TS_W(TS_W)) bus ();

  ch_thresh_scan_ctrl #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TS_W(TS_W), .HOLD_CNT(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [TS_W-1:0] tof(input int ch);
    return bus.tof_ts[ch*TS_W +: TS_W];
  endfunction

  task automatic cyc();
    @(posedge clk);
    tb_t++;
    @(negedge clk);
  endtask

  task automatic run_to(input int t);
    while (tb_t < t) cyc();
  endtask

  task automatic clr_smp();
    bus.sample_valid = '0;
    bus.sample_data  = '0;
  endtask

  task automatic smp(input int ch, input logic [DATA_W-1:0] d);
    bus.sample_valid[ch] = 1'b1;
    bus.sample_data[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic shot(input logic [DATA_W-1:0] t0, input logic [DATA_W-1:0] t1,
                      input logic [DATA_W-1:0] t2, input logic [DATA_W-1:0] t3,
                      input logic [15:0] blank, input logic [TS_W-1:0] tmo);
    bus.thresh_in    = {t3, t2, t1, t0};
    bus.blank_cycles = blank;
    bus.timeout      = tmo;
    bus.arm          = 1'b1;
    @(posedge clk);
    tb_t = 0;
    @(negedge clk);
    bus.arm = 1'b0;
  endtask

  task automatic ack_irq();
    bus.irq_ack = 1'b1;
    cyc();
    bus.irq_ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] hyst [8];
    hyst = '{24'd600, 24'd600, 24'd600, 24'd400, 24'd600, 24'd600, 24'd600, 24'd600};

    bus.arm = 1'b0; bus.abort = 1'b0; bus.irq_ack = 1'b0;
    bus.blank_cycles = '0; bus.timeout = '0; bus.thresh_in = '0;
    clr_smp();
    repeat (3) @(negedge clk);
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_irq", 128'(bus.irq), 128'd0);
    check("rst_hit", 128'(bus.hit_mask), 128'd0);
    check("rst_ovr", 128'(bus.overrun), 128'd0);
    check("rst_tof", 128'(bus.tof_ts), 128'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Shot 1: blanking then basic hit on ch0, timeout-driven DONE.
    shot(24'd1000, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 16'd10, 32'd5000);
    for (int i = 0; i < 10; i++) begin
      for (int ch = 0; ch < NUM_CH; ch++) smp(ch, 24'hFFFFFF);
      cyc();
    end
    clr_smp();
    check("blank_hit", 128'(bus.hit_mask), 128'd0);
    check("blank_ovr", 128'(bus.overrun), 128'd0);
    check("blank_busy", 128'(bus.busy), 128'd1);
    run_to(50);
    for (int i = 0; i < 4; i++) begin
      smp(0, 24'd1200);
      cyc();
    end
    clr_smp();
    check("basic_pre_hit", 128'(bus.hit_mask), 128'd0);
    cyc();
    check("basic_hit", 128'(bus.hit_mask), 128'h1);
    check("basic_tof0", 128'(tof(0)), 128'd53);
    run_to(4999);
    check("basic_irq_pre", 128'(bus.irq), 128'd0);
    check("basic_busy_pre", 128'(bus.busy), 128'd1);
    cyc();
    check("basic_irq", 128'(bus.irq), 128'd1);
    check("basic_busy_done", 128'(bus.busy), 128'd0);
    check("basic_hit_final", 128'(bus.hit_mask), 128'h1);
    cyc();
    check("basic_irq_held", 128'(bus.irq), 128'd1);
    ack_irq();
    check("basic_irq_ack", 128'(bus.irq), 128'd0);

    // Shot 2: hysteresis on ch1, equality hit on ch0, all-hit early DONE.
    shot(24'd1000, 24'd500, 24'd0, 24'd0, 16'd0, 32'd1000);
    run_to(5);
    for (int i = 0; i < 8; i++) begin
      smp(1, hyst[i]);
      cyc();
    end
    clr_smp();
    check("hyst_pre", 128'(bus.hit_mask), 128'd0);
    cyc();
    check("hyst_hit", 128'(bus.hit_mask), 128'h2);
    check("hyst_tof1", 128'(tof(1)), 128'd12);
    run_to(20);
    for (int i = 0; i < 4; i++) begin
      smp(0, 24'd1000);
      cyc();
    end
    clr_smp();
    check("eq_pre_busy", 128'(bus.busy), 128'd1);
    cyc();
    check("eq_irq", 128'(bus.irq), 128'd1);
    check("eq_busy", 128'(bus.busy), 128'd0);
    check("eq_hit", 128'(bus.hit_mask), 128'h3);
    check("eq_tof0", 128'(tof(0)), 128'd23);
    ack_irq();

    // Shot 3: staggered strobes, one per channel every 4 cycles -> no overrun.
    shot(24'd1000, 24'd1000, 24'd1000, 24'd1000, 16'd0, 32'd200);
    run_to(8);
    for (int c = 0; c < 16; c++) begin
      smp(c % 4, 24'd2000);
      cyc();
      clr_smp();
    end
    check("stag_hit_partial", 128'(bus.hit_mask), 128'h7);
    check("stag_ovr_mid", 128'(bus.overrun), 128'd0);
    cyc();
    check("stag_hit", 128'(bus.hit_mask), 128'hF);
    check("stag_irq", 128'(bus.irq), 128'd1);
    check("stag_ovr", 128'(bus.overrun), 128'd0);
    for (int ch = 0; ch < NUM_CH; ch++) check($sformatf("stag_tof%0d", ch), 128'(tof(ch)), 128'(20 + ch));
    ack_irq();

    // Shot 4: every channel strobes every cycle -> overrun, then abort with arm.
    shot(24'd1000, 24'd1000, 24'd1000, 24'd1000, 16'd0, 32'd500);
    run_to(3);
    for (int i = 0; i < 4; i++) begin
      for (int ch = 0; ch < NUM_CH; ch++) smp(ch, 24'd1);
      cyc();
    end
    clr_smp();
    check("ovr_all", 128'(bus.overrun), 128'hF);
    run_to(100);
    bus.abort = 1'b1;
    bus.arm   = 1'b1;
    cyc();
    bus.abort = 1'b0;
    bus.arm   = 1'b0;
    check("abort_busy", 128'(bus.busy), 128'd0);
    check("abort_ovr_kept", 128'(bus.overrun), 128'hF);
    cyc();
    cyc();
    check("abort_no_irq", 128'(bus.irq), 128'd0);
    bus.abort = 1'b1;
    bus.arm   = 1'b1;
    cyc();
    bus.abort = 1'b0;
    bus.arm   = 1'b0;
    check("abort_beats_arm", 128'(bus.busy), 128'd0);

    // Shot 5: ch2 disabled, early DONE with irq_ack on the DONE-entry edge.
    shot(24'd1000, 24'd1000, 24'd0, 24'd1000, 16'd10, 32'd5000);
    run_to(100);
    for (int i = 0; i < 4; i++) begin
      smp(0, 24'd1500);
      smp(2, 24'hFFFFFF);
      cyc();
    end
    clr_smp();
    run_to(200);
    for (int i = 0; i < 4; i++) begin
      smp(1, 24'd1500);
      cyc();
    end
    clr_smp();
    run_to(297);
    for (int i = 0; i < 4; i++) begin
      smp(3, 24'd1500);
      cyc();
    end
    clr_smp();
    check("early_pre_hit", 128'(bus.hit_mask), 128'h3);
    check("early_pre_busy", 128'(bus.busy), 128'd1);
    bus.irq_ack = 1'b1;
    cyc();
    bus.irq_ack = 1'b0;
    check("early_irq_acked", 128'(bus.irq), 128'd0);
    check("early_busy", 128'(bus.busy), 128'd0);
    check("early_hit", 128'(bus.hit_mask), 128'hB);
    check("early_tof3", 128'(tof(3)), 128'd300);
    check("early_tof2", 128'(tof(2)), 128'd0);
    check("early_ovr", 128'(bus.overrun), 128'd0);
    cyc();
    check("early_irq_after", 128'(bus.irq), 128'd0);

    // Shot 6: reset asserted mid-SCAN.
    shot(24'd1000, 24'd1000, 24'd1000, 24'd1000, 16'd0, 32'd500);
    run_to(5);
    for (int i = 0; i < 4; i++) begin
      for (int ch = 0; ch < NUM_CH; ch++) smp(ch, 24'd1);
      cyc();
    end
    clr_smp();
    check("rstmid_ovr_pre", 128'(bus.overrun), 128'hF);
    check("rstmid_busy_pre", 128'(bus.busy), 128'd1);
    reset_n = 1'b0;
    #1;
    check("rstmid_busy", 128'(bus.busy), 128'd0);
    check("rstmid_ovr", 128'(bus.overrun), 128'd0);
    check("rstmid_hit", 128'(bus.hit_mask), 128'd0);
    check("rstmid_irq", 128'(bus.irq), 128'd0);
    check("rstmid_tof", 128'(bus.tof_ts), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cyc();
    check("rstmid_idle", 128'(bus.busy), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
